fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Synchronous FIFO built around the team's `dpr_sync` dual-port RAM. The block sits directly upstream of the RAM: it converts push/pop requests into RAM write/read strobes and addresses, and keeps read/write pointers, occupancy count and status flags. It also flags rejected accesses and qualifies the RAM's registered read data with a valid strobe.

## Interface
- `MEM_WIDTH`, 16, data width.
- `MEM_DEPTH`, 1024, FIFO depth. Must equal 2**`ADDR_SIZE`.
- `ADDR_SIZE`, 10, RAM address width.
- `AF_MARGIN`, 4, `almost_full` threshold: asserts when `count >= MEM_DEPTH - AF_MARGIN`.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset, also routed to the RAM's `rst`.
- `wr_req` in 1: push request.
- `wr_data` in `MEM_WIDTH`: push data.
- `rd_req` in 1: pop request.
- `rd_data` out `MEM_WIDTH`: RAM `dout`, passed through.
- `rd_valid` out 1: `rd_data` holds the popped word this cycle.
- `full` out 1: `count == MEM_DEPTH`.
- `empty` out 1: `count == 0`.
- `almost_full` out 1: occupancy at or above the threshold.
- `count` out `ADDR_SIZE+1`: current occupancy.
- `overflow` out 1: one-cycle pulse when a push is rejected.
- `underflow` out 1: one-cycle pulse when a pop is rejected.

## Operation
- Accept rules: `push_ok = wr_req & ~full`, `pop_ok = rd_req & ~empty`. Both are evaluated on the pre-edge state.
- RAM drive (combinational):
  - `wr_en = push_ok`, `rd_en = pop_ok`.
  - `blk_select = push_ok | pop_ok`.
  - `din = wr_data`.
  - `addr_wr = wptr[ADDR_SIZE-1:0]`, `addr_rd = rptr[ADDR_SIZE-1:0]`.
- Pointers `wptr` and `rptr` are `ADDR_SIZE+1` bits wide. Each increments by 1 on its accepted access and wraps naturally, so address bits roll over from 1023 to 0.
- Count update:
  - +1 on `push_ok & ~pop_ok`.
  - −1 on `pop_ok & ~push_ok`.
  - Unchanged when both are accepted or neither is.
- `full`, `empty` and `almost_full` decode combinationally from the registered `count` only.
- Simultaneous push and pop:
  - When neither full nor empty: both are accepted and `count` is held.
  - When `full`: the push is rejected (`overflow`), the pop is accepted, and `count` becomes `MEM_DEPTH-1`.
  - When `empty`: the pop is rejected (`underflow`), the push is accepted, and `count` becomes 1. There is no write-through bypass and no `rd_valid`.
- `overflow` is registered as `wr_req & full`; `underflow` is registered as `rd_req & empty`. Each lasts one cycle per rejected request.
- Reset (at any time, including mid-burst) asynchronously clears:
  - pointers, `count`, `rd_valid`, `overflow` and `underflow` to 0;
  - which leaves `empty=1`, `full=0`, `almost_full=0`.
- After reset, RAM contents are stale but unreachable. A read that was in flight at reset never produces `rd_valid`.

## Timing
- Push latency: the word is written at edge N, where `push_ok` is high. It is poppable from cycle N+1.
- Pop latency: with `pop_ok` at edge N, RAM `dout` updates at edge N. `rd_valid` is registered from `pop_ok` and is high in cycle N+1, aligned with `rd_data`.
- Back-to-back pops give one word per cycle. `rd_data` is undefined whenever `rd_valid=0`.
- Flags and `count` reflect accepted operations one edge later. `full` can deassert in the same cycle as a pop at full.
- There are no combinational paths from `rd_data` to any input.

## Structure
- Package `fifo_pkg` holds:
  - the default `MEM_WIDTH`, `MEM_DEPTH`, `ADDR_SIZE` and `AF_MARGIN` constants;
  - a pointer-width constant (`ADDR_SIZE+1`).
- One sub-module, `dpr_sync`, is instantiated as the storage array, with ports wired positionally in its existing order: din, addr_wr, addr_rd, wr_en, rd_en, blk_select, clk, rst, dout.
- Pointer/count logic stays inline. There is no separate FSM; state is the pointers plus `count`.

## Test plan
- Reset, then idle: `empty=1`, `full=0`, `count=0`, `rd_valid=0`. Assert `rst` mid-fill at `count=37`: `count` goes to 0 immediately, without waiting for a clock edge.
- Push 1024 words 0x0000..0x03FF, then push 0xBEEF: `full=1`, `count=1024`, `almost_full` from `count=1020`, and `overflow` pulses once. The RAM never sees a write for 0xBEEF.
- Pop 1024 words: `rd_data` returns 0x0000..0x03FF in order, each with `rd_valid` one cycle after its pop. Finishes with `empty=1`. An extra pop pulses `underflow` with no `rd_valid`.
- Wrap-around: push/pop 1500 random words in a mixed interleave with `count` kept ≤ 8. Output matches a scoreboard and `addr_wr` rolls over from 1023 to 0.
- Simultaneous `wr_req`/`rd_req`:
  - at `count=5`: `count` stays 5;
  - at full: `count=1023` plus `overflow`;
  - at empty: `count=1` plus `underflow`, no `rd_valid`.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults for the FIFO controller and its dual-port RAM.
package fifo_pkg;

  localparam int FIFO_MEM_WIDTH = 16;
  localparam int FIFO_MEM_DEPTH = 1024;
  localparam int FIFO_ADDR_SIZE = 10;
  localparam int FIFO_AF_MARGIN = 4;
  localparam int FIFO_PTR_WIDTH = FIFO_ADDR_SIZE + 1;

  // Net effect of one cycle's accepted accesses on the occupancy count.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_INC  = 2'b01,
    CNT_DEC  = 2'b10
  } cnt_op_e;

endpackage

// File: rtl/dpr_sync.sv
// Synchronous dual-port RAM: one write port, one read port with registered dout,
// both gated by blk_select.
module dpr_sync
  import fifo_pkg::*;
#(
  parameter int MEM_WIDTH = FIFO_MEM_WIDTH,
  parameter int MEM_DEPTH = FIFO_MEM_DEPTH,
  parameter int ADDR_SIZE = FIFO_ADDR_SIZE
) (
  input  logic [MEM_WIDTH-1:0] din,
  input  logic [ADDR_SIZE-1:0] addr_wr,
  input  logic [ADDR_SIZE-1:0] addr_rd,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic                 blk_select,
  input  logic                 clk,
  input  logic                 rst,
  output logic [MEM_WIDTH-1:0] dout
);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  // NOTE: the storage array has no reset; clearing it would force flops in place
  // of RAM macros, and stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (blk_select && wr_en) mem[addr_wr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      dout <= '0;
    else if (blk_select && rd_en) dout <= mem[addr_rd];
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: turns push/pop requests into dpr_sync strobes and keeps the
// pointers, occupancy count, status flags and read-valid qualifier.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int MEM_WIDTH = FIFO_MEM_WIDTH,
  parameter int MEM_DEPTH = FIFO_MEM_DEPTH,
  parameter int ADDR_SIZE = FIFO_ADDR_SIZE,
  parameter int AF_MARGIN = FIFO_AF_MARGIN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req,
  input  logic [MEM_WIDTH-1:0] wr_data,
  input  logic                 rd_req,
  output logic [MEM_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int PTR_W = ADDR_SIZE + 1;
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(MEM_DEPTH);
  localparam logic [PTR_W-1:0] AF_LEVEL  = PTR_W'(MEM_DEPTH - AF_MARGIN);

  logic [PTR_W-1:0]     wptr, rptr;
  logic                 push_ok, pop_ok;
  logic                 wr_en, rd_en, blk_select;
  logic [ADDR_SIZE-1:0] addr_wr, addr_rd;
  cnt_op_e              cnt_op;

  assign full        = (count == DEPTH_CNT);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_LEVEL);

  assign push_ok    = wr_req & ~full;
  assign pop_ok     = rd_req & ~empty;
  assign wr_en      = push_ok;
  assign rd_en      = pop_ok;
  assign blk_select = push_ok | pop_ok;
  assign addr_wr    = wptr[ADDR_SIZE-1:0];
  assign addr_rd    = rptr[ADDR_SIZE-1:0];

  // NOTE: the default assignment up front keeps every path driven, so no latch
  // is inferred when neither or both accesses are accepted.
  always_comb begin
    cnt_op = CNT_HOLD;
    if (push_ok && !pop_ok)      cnt_op = CNT_INC;
    else if (pop_ok && !push_ok) cnt_op = CNT_DEC;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, matching the accept rules evaluated on the old count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop_ok)  rptr <= rptr + PTR_W'(1);
      case (cnt_op)
        CNT_INC: count <= count + PTR_W'(1);
        CNT_DEC: count <= count - PTR_W'(1);
        default: count <= count;
      endcase
      rd_valid  <= pop_ok;
      overflow  <= wr_req & full;
      underflow <= rd_req & empty;
    end
  end

  dpr_sync #(
    .MEM_WIDTH(MEM_WIDTH),
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    wr_data, addr_wr, addr_rd, wr_en, rd_en, blk_select, clk, rst, rd_data
  );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomised scoreboard bench for fifo_ctrl against a queue-based FIFO model.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DEPTH = FIFO_MEM_DEPTH;
  localparam int AFM   = FIFO_AF_MARGIN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid, full, empty, almost_full, overflow, underflow;
  logic [10:0] count;

  fifo_ctrl dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  logic [15:0] model_q[$];  // words currently stored in the FIFO
  logic [15:0] sb_q[$];     // popped words waiting to appear on rd_data
  bit          exp_valid, exp_ovf, exp_unf;
  int          wr_total;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  bit          saw_wrap = 1'b0;
  logic [9:0]  prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model applies the accept rules on the
  // pre-edge occupancy and queues the data the DUT must return.
  task automatic step(input bit wr, input bit rd, input logic [15:0] d);
    bit push_ok, pop_ok;
    wr_req = wr; rd_req = rd; wr_data = d;
    push_ok = wr && (model_q.size() < DEPTH);
    pop_ok  = rd && (model_q.size() != 0);
    @(posedge clk);
    exp_ovf   = wr && (model_q.size() == DEPTH);
    exp_unf   = rd && (model_q.size() == 0);
    exp_valid = pop_ok;
    if (pop_ok)  sb_q.push_back(model_q.pop_front());
    if (push_ok) begin model_q.push_back(d); wr_total++; end
    #1;
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("rd_valid", rd_valid, exp_valid);
      if (rd_valid) begin
        if (sb_q.size() == 0) check("rd_valid_unexpected", 1, 0);
        else check("rd_data", rd_data, sb_q.pop_front());
      end
      check("count", count, model_q.size());
      check("empty", empty, model_q.size() == 0);
      check("full", full, model_q.size() == DEPTH);
      check("almost_full", almost_full, model_q.size() >= DEPTH - AFM);
      check("overflow", overflow, exp_ovf);
      check("underflow", underflow, exp_unf);
      check("addr_wr", dut.addr_wr, wr_total % DEPTH);
      if (prev_addr == 10'd1023 && dut.addr_wr == 10'd0) saw_wrap = 1'b1;
      prev_addr = dut.addr_wr;
    end
  end

  task automatic model_reset();
    model_q.delete(); sb_q.delete();
    exp_valid = 0; exp_ovf = 0; exp_unf = 0; wr_total = 0;
  endtask

  initial begin
    int pushed;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_count", count, 0);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_rd_valid", rd_valid, 0);
    mon_en = 1'b1;
    repeat (3) step(0, 0, '0);

    // Fill to 37, leave a pop in flight, then reset between edges.
    for (int i = 0; i < 37; i++) step(1, 0, 16'($urandom));
    rd_req = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_empty", empty, 1);
    check("async_rst_full", full, 0);
    check("async_rst_af", almost_full, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0; rd_req = 1'b0;
    step(0, 0, '0);

    // Fill completely, then one rejected push.
    for (int i = 0; i < DEPTH; i++) step(1, 0, 16'(i));
    step(1, 0, 16'hBEEF);
    step(0, 0, '0);

    // Drain in order, then one rejected pop.
    for (int i = 0; i < DEPTH; i++) step(0, 1, '0);
    step(0, 1, '0);
    step(0, 0, '0);

    // Shallow random interleave across the address rollover.
    pushed = 0;
    while (pushed < 1500) begin
      bit w, r;
      w = (model_q.size() < 8) ? bit'($urandom_range(0, 1)) : 1'b0;
      r = bit'($urandom_range(0, 1));
      if (w) pushed++;
      step(w, r, 16'($urandom));
    end
    while (model_q.size() != 0) step(0, 1, '0);
    step(0, 0, '0);

    // Simultaneous push and pop at count=5, at full and at empty.
    for (int i = 0; i < 5; i++) step(1, 0, 16'($urandom));
    step(1, 1, 16'h1234);
    step(0, 0, '0);
    while (model_q.size() < DEPTH) step(1, 0, 16'($urandom));
    step(1, 1, 16'h5678);
    step(0, 0, '0);
    while (model_q.size() != 0) step(0, 1, '0);
    step(0, 0, '0);
    step(1, 1, 16'h9ABC);
    step(0, 0, '0);
    step(0, 1, '0);
    repeat (3) step(0, 0, '0);

    check("addr_wr_rollover", saw_wrap, 1);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
